// File: rtl/sumador_monitor_pkg.sv
// Shared definitions for the sumador result checker: default adder geometry
// and the monitor FSM state encodings.
package sumador_monitor_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/sumador_monitor_linea_retardo.sv
// Fixed-depth register delay line with asynchronous active-low clear and a
// hold input that freezes every stage.
module linea_retardo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_clr_n,
    input  logic              i_hold,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (!i_hold) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/sumador_monitor.sv
// Result checker for the pipelined adder: rebuilds the expected sum/index
// through a matched delay line and keeps sticky flags and saturating counters.
module sumador_monitor
    import sumador_monitor_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int LATENCY     = LATENCY_DEF,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [WIDTH-1:0] sum30_dd,
    input  logic [WIDTH-1:0] idx_dd,
    output logic             err,
    output logic             err_sum,
    output logic             err_idx,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam int FL_W = $clog2(LATENCY + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FL_W-1:0]    r_flush_cnt;
    logic [WIDTH-1:0]   r_idx_cnt;
    logic [WIDTH-1:0]   w_sum_in;
    logic [2*WIDTH-1:0] w_line_out;
    logic               w_hold;
    logic               w_flush_done;
    logic               w_cmp_en;
    logic               w_sum_bad;
    logic               w_idx_bad;
    logic               w_mis;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Carry is dropped: the adder result is WIDTH bits wide.
    assign w_sum_in     = dataA + dataB;
    assign w_hold       = (r_state == HALT);
    assign w_flush_done = (r_state == FLUSH) && (r_flush_cnt == FL_W'(LATENCY));
    assign w_cmp_en     = (r_state == CHECK) || w_flush_done;
    assign w_sum_bad    = w_cmp_en && (w_line_out[2*WIDTH-1:WIDTH] != sum30_dd);
    assign w_idx_bad    = w_cmp_en && (w_line_out[WIDTH-1:0] != idx_dd);
    assign w_mis        = w_sum_bad || w_idx_bad;
    assign busy         = (r_state == CHECK);

    linea_retardo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (LATENCY)
    ) u_linea (
        .i_clk   (clk),
        .i_clr_n (reset_L),
        .i_hold  (w_hold),
        .i_d     ({w_sum_in, r_idx_cnt}),
        .o_q     (w_line_out)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= FLUSH;
            r_flush_cnt <= '0;
            r_idx_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == FLUSH) && !w_flush_done) begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end
            if (!w_hold) begin
                r_idx_cnt <= r_idx_cnt + WIDTH'(1);
            end
        end
    end

    // The last flush edge already performs the first comparison, so a
    // mismatch there can go straight to HALT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FLUSH: begin
                if (w_flush_done) begin
                    w_state_nxt = (STOP_ON_ERR && w_mis) ? HALT : CHECK;
                end
            end
            CHECK: begin
                if (STOP_ON_ERR && w_mis) begin
                    w_state_nxt = HALT;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err       <= 1'b0;
            err_sum   <= 1'b0;
            err_idx   <= 1'b0;
            chk_count <= '0;
            err_count <= '0;
        end else begin
            err <= w_mis;
            if (w_sum_bad) begin
                err_sum <= 1'b1;
            end
            if (w_idx_bad) begin
                err_idx <= 1'b1;
            end
            if (w_cmp_en) begin
                chk_count <= sat_inc(chk_count);
            end
            if (w_mis) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule
